// File: rtl/unidade_controle_jogo.sv
// ---------------------------------------------------------------------------
// unidade_controle_jogo
//
// Moore control FSM for the memory game. It drives the fluxo_dados datapath
// (address / limit / display / timeout counters and the play register). Each
// round shows ROM items 0..limite on the LEDs, then waits for one play per
// item and checks it. The game is won when the final limit round passes.
// A wrong play or a play timeout loses the game.
//
// Ports
//   clock               in   rising-edge system clock
//   reset               in   asynchronous, active-low; forces state inicial
//   iniciar             in   start / restart request (level)
//   botoesIgualMemoria  in   registered play equals ROM data
//   endecoIgualLimite   in   address counter equals limit counter
//   fimL                in   limit counter at its last value (final round)
//   fimM                in   display counter at terminal count
//   jogada_feita        in   one-cycle pulse on a button edge
//   timeout             in   play-timeout counter terminal count
//   zeraE/L/R/M         out  clear address, limit, play register, display
//   contaE/L/M          out  increment address, limit, display counters
//   registraR           out  load the play register from the buttons
//   contaT              out  enable timeout counter (0 also clears it)
//   seletor[1:0]        out  LED mux: 00 off, 01 ROM data, 10 registered play
//   pronto/ganhou/perdeu out game finished / won / lost
//   db_timeout          out  the loss was caused by a timeout
//   db_estado[4:0]      out  current state code
//
// Parameter
//   EXIBE_APAGADO  1: blank LEDs for one display period between shown items
// ---------------------------------------------------------------------------
module unidade_controle_jogo #(
    parameter logic EXIBE_APAGADO = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       botoesIgualMemoria,
    input  logic       endecoIgualLimite,
    input  logic       fimL,
    input  logic       fimM,
    input  logic       jogada_feita,
    input  logic       timeout,
    output logic       zeraE,
    output logic       zeraL,
    output logic       zeraR,
    output logic       zeraM,
    output logic       contaE,
    output logic       contaL,
    output logic       contaM,
    output logic       registraR,
    output logic       contaT,
    output logic [1:0] seletor,
    output logic       pronto,
    output logic       ganhou,
    output logic       perdeu,
    output logic       db_timeout,
    output logic [4:0] db_estado
);

    localparam logic [4:0] INICIAL        = 5'h00;
    localparam logic [4:0] PREPARACAO     = 5'h01;
    localparam logic [4:0] INICIA_RODADA  = 5'h02;
    localparam logic [4:0] MOSTRA         = 5'h03;
    localparam logic [4:0] PROXIMO_MOSTRA = 5'h04;
    localparam logic [4:0] APAGA          = 5'h05;
    localparam logic [4:0] FIM_MOSTRA     = 5'h06;
    localparam logic [4:0] ESPERA         = 5'h07;
    localparam logic [4:0] REGISTRA       = 5'h08;
    localparam logic [4:0] COMPARACAO     = 5'h09;
    localparam logic [4:0] PROXIMA_JOGADA = 5'h0A;
    localparam logic [4:0] PROXIMA_RODADA = 5'h0B;
    localparam logic [4:0] FINAL_ACERTOU  = 5'h0C;
    localparam logic [4:0] FINAL_ERROU    = 5'h0D;
    localparam logic [4:0] FINAL_TIMEOUT  = 5'h0E;
    localparam logic [4:0] APAGA_FIM      = 5'h0F;

    localparam logic [1:0] SEL_OFF   = 2'b00;
    localparam logic [1:0] SEL_ROM   = 2'b01;
    localparam logic [1:0] SEL_PLAY  = 2'b10;

    logic [4:0] state_reg;
    logic [4:0] state_next;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= INICIAL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INICIAL:        state_next = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     state_next = INICIA_RODADA;
            INICIA_RODADA:  state_next = MOSTRA;
            MOSTRA: begin
                if (fimM) begin
                    state_next = endecoIgualLimite ? FIM_MOSTRA : PROXIMO_MOSTRA;
                end
            end
            PROXIMO_MOSTRA: state_next = EXIBE_APAGADO ? APAGA : MOSTRA;
            APAGA:          state_next = fimM ? APAGA_FIM : APAGA;
            // Extra state so the display counter restarts from zero for the next item
            APAGA_FIM:      state_next = MOSTRA;
            FIM_MOSTRA:     state_next = ESPERA;
            ESPERA: begin
                // A play arriving in the same cycle as the timeout still counts
                if (jogada_feita) begin
                    state_next = REGISTRA;
                end else if (timeout) begin
                    state_next = FINAL_TIMEOUT;
                end
            end
            REGISTRA:       state_next = COMPARACAO;
            COMPARACAO: begin
                if (!botoesIgualMemoria) begin
                    state_next = FINAL_ERROU;
                end else if (!endecoIgualLimite) begin
                    state_next = PROXIMA_JOGADA;
                end else if (fimL) begin
                    state_next = FINAL_ACERTOU;
                end else begin
                    state_next = PROXIMA_RODADA;
                end
            end
            PROXIMA_JOGADA: state_next = ESPERA;
            PROXIMA_RODADA: state_next = INICIA_RODADA;
            FINAL_ACERTOU,
            FINAL_ERROU,
            FINAL_TIMEOUT:  state_next = iniciar ? PREPARACAO : state_reg;
            default:        state_next = INICIAL;
        endcase
    end

    // Moore output decode
    always_comb begin
        zeraE      = 1'b0;
        zeraL      = 1'b0;
        zeraR      = 1'b0;
        zeraM      = 1'b0;
        contaE     = 1'b0;
        contaL     = 1'b0;
        contaM     = 1'b0;
        registraR  = 1'b0;
        contaT     = 1'b0;
        seletor    = SEL_OFF;
        pronto     = 1'b0;
        ganhou     = 1'b0;
        perdeu     = 1'b0;
        db_timeout = 1'b0;
        case (state_reg)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
                zeraM = 1'b1;
            end
            INICIA_RODADA: begin
                zeraE = 1'b1;
                zeraR = 1'b1;
                zeraM = 1'b1;
            end
            MOSTRA: begin
                seletor = SEL_ROM;
                contaM  = 1'b1;
            end
            PROXIMO_MOSTRA: begin
                contaE = 1'b1;
                zeraM  = 1'b1;
            end
            APAGA: begin
                seletor = SEL_OFF;
                contaM  = 1'b1;
            end
            APAGA_FIM: begin
                zeraM = 1'b1;
            end
            FIM_MOSTRA: begin
                zeraE = 1'b1;
                zeraR = 1'b1;
            end
            ESPERA: begin
                seletor = SEL_PLAY;
                contaT  = 1'b1;
            end
            REGISTRA: begin
                registraR = 1'b1;
                seletor   = SEL_PLAY;
            end
            COMPARACAO: begin
                seletor = SEL_PLAY;
            end
            PROXIMA_JOGADA: begin
                contaE = 1'b1;
            end
            PROXIMA_RODADA: begin
                contaL = 1'b1;
            end
            FINAL_ACERTOU: begin
                pronto  = 1'b1;
                ganhou  = 1'b1;
                seletor = SEL_PLAY;
            end
            FINAL_ERROU: begin
                pronto  = 1'b1;
                perdeu  = 1'b1;
                seletor = SEL_PLAY;
            end
            FINAL_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = state_reg;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// ---------------------------------------------------------------------------
// Testbench for unidade_controle_jogo (EXIBE_APAGADO = 1).
// Each step drives the datapath status inputs, pushes the expected state and
// Moore outputs to a scoreboard queue, clocks once, then pops and compares
// against db_estado plus all control outputs.
// ---------------------------------------------------------------------------
module tb_unidade_controle_jogo;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       botoesIgualMemoria = 1'b0;
    logic       endecoIgualLimite = 1'b0;
    logic       fimL = 1'b0;
    logic       fimM = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       timeout = 1'b0;
    logic       zeraE, zeraL, zeraR, zeraM;
    logic       contaE, contaL, contaM;
    logic       registraR, contaT;
    logic [1:0] seletor;
    logic       pronto, ganhou, perdeu, db_timeout;
    logic [4:0] db_estado;

    unidade_controle_jogo #(.EXIBE_APAGADO(1'b1)) dut (
        .clock              (clock),
        .reset              (reset),
        .iniciar            (iniciar),
        .botoesIgualMemoria (botoesIgualMemoria),
        .endecoIgualLimite  (endecoIgualLimite),
        .fimL               (fimL),
        .fimM               (fimM),
        .jogada_feita       (jogada_feita),
        .timeout            (timeout),
        .zeraE              (zeraE),
        .zeraL              (zeraL),
        .zeraR              (zeraR),
        .zeraM              (zeraM),
        .contaE             (contaE),
        .contaL             (contaL),
        .contaM             (contaM),
        .registraR          (registraR),
        .contaT             (contaT),
        .seletor            (seletor),
        .pronto             (pronto),
        .ganhou             (ganhou),
        .perdeu             (perdeu),
        .db_timeout         (db_timeout),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    // {db_estado, zeraE, zeraL, zeraR, zeraM, contaE, contaL, contaM,
    //  registraR, contaT, seletor, pronto, ganhou, perdeu, db_timeout}
    logic [19:0] obs;
    assign obs = {db_estado, zeraE, zeraL, zeraR, zeraM, contaE, contaL, contaM,
                  registraR, contaT, seletor, pronto, ganhou, perdeu, db_timeout};

    // Input bundle order: {iniciar, eq, endeco, fimL, fimM, jogada, timeout}
    localparam logic [6:0] I_NONE = 7'b0000000;
    localparam logic [6:0] I_INI  = 7'b1000000;
    localparam logic [6:0] I_EQ   = 7'b0100000;
    localparam logic [6:0] I_END  = 7'b0010000;
    localparam logic [6:0] I_FL   = 7'b0001000;
    localparam logic [6:0] I_FM   = 7'b0000100;
    localparam logic [6:0] I_JF   = 7'b0000010;
    localparam logic [6:0] I_TO   = 7'b0000001;

    typedef struct {
        logic [6:0] in;
        logic [4:0] st;
    } step_t;

    step_t       stim_q[$];
    logic [19:0] exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;

    // Expected Moore outputs for a state, straight from the state table.
    function automatic logic [19:0] expect_vec(input logic [4:0] st);
        logic zE, zL, zR, zM, cE, cL, cM, rR, cT, pr, ga, pe, dt;
        logic [1:0] sel;
        {zE, zL, zR, zM, cE, cL, cM, rR, cT, pr, ga, pe, dt} = '0;
        sel = 2'b00;
        case (st)
            5'h01: {zE, zL, zR, zM} = 4'b1111;
            5'h02: {zE, zR, zM} = 3'b111;
            5'h03: begin sel = 2'b01; cM = 1'b1; end
            5'h04: begin cE = 1'b1; zM = 1'b1; end
            5'h05: cM = 1'b1;
            5'h0F: zM = 1'b1;
            5'h06: {zE, zR} = 2'b11;
            5'h07: begin sel = 2'b10; cT = 1'b1; end
            5'h08: begin sel = 2'b10; rR = 1'b1; end
            5'h09: sel = 2'b10;
            5'h0A: cE = 1'b1;
            5'h0B: cL = 1'b1;
            5'h0C: begin sel = 2'b10; pr = 1'b1; ga = 1'b1; end
            5'h0D: begin sel = 2'b10; pr = 1'b1; pe = 1'b1; end
            5'h0E: begin pr = 1'b1; pe = 1'b1; dt = 1'b1; end
            default: ;
        endcase
        return {st, zE, zL, zR, zM, cE, cL, cM, rR, cT, sel, pr, ga, pe, dt};
    endfunction

    task automatic add(input logic [6:0] in, input logic [4:0] st, input int n = 1);
        step_t s;
        s.in = in;
        s.st = st;
        for (int i = 0; i < n; i++) stim_q.push_back(s);
    endtask

    task automatic drive(input logic [6:0] in);
        {iniciar, botoesIgualMemoria, endecoIgualLimite, fimL, fimM, jogada_feita, timeout} = in;
    endtask

    task automatic test_reset();
        step_t s;
        logic [19:0] e;
        int k = 0;
        // Power-on reset held low
        #2;
        n_total++;
        if (obs !== 20'h0) $display("FAIL reset_initial: got %h required %h", obs, 20'h0);
        else n_pass++;
        @(negedge clock);
        reset = 1'b1;
        add(I_NONE, 5'h00);
        add(I_INI,  5'h01);
        add(I_NONE, 5'h02);
        add(I_NONE, 5'h03, 3);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL reset_start step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            k++;
        end
        // Asynchronous reset in the middle of mostra, away from any edge
        #3;
        reset = 1'b0;
        #1;
        n_total++;
        if (obs !== 20'h0) $display("FAIL reset_async: got %h required %h", obs, 20'h0);
        else n_pass++;
        @(posedge clock); #1;
        n_total++;
        if (obs !== 20'h0) $display("FAIL reset_held: got %h required %h", obs, 20'h0);
        else n_pass++;
        reset = 1'b1;
        // Holding iniciar must not restart the game mid-round
        add(I_INI, 5'h01);
        add(I_INI, 5'h02);
        add(I_INI, 5'h03);
        add(I_INI, 5'h03, 2);
        add(I_NONE, 5'h03);
        k = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL reset_restart step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_round0();
        step_t s;
        logic [19:0] e;
        int k = 0;
        int conta_l = 0;
        add(I_NONE, 5'h03, 998);
        add(I_FM | I_END, 5'h06);
        add(I_NONE, 5'h07);
        add(I_JF, 5'h08);
        add(I_NONE, 5'h09);
        add(I_EQ | I_END, 5'h0B);
        add(I_NONE, 5'h02);
        add(I_NONE, 5'h03);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL round0 step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            if (contaL === 1'b1) conta_l++;
            k++;
        end
        n_total++;
        if (conta_l !== 1) $display("FAIL round0_contaL_pulses: got %0d required %0d", conta_l, 1);
        else n_pass++;
    endtask

    task automatic test_round2_blank();
        step_t s;
        logic [19:0] e;
        int k = 0;
        int conta_e = 0;
        add(I_FM, 5'h04);
        add(I_NONE, 5'h05);
        add(I_NONE, 5'h05, 2);
        add(I_FM, 5'h0F);
        add(I_NONE, 5'h03);
        add(I_NONE, 5'h03);
        add(I_FM, 5'h04);
        add(I_NONE, 5'h05);
        add(I_FM, 5'h0F);
        add(I_NONE, 5'h03);
        add(I_FM | I_END, 5'h06);
        add(I_NONE, 5'h07);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL round2_show step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            if (contaE === 1'b1) conta_e++;
            k++;
        end
        n_total++;
        if (conta_e !== 2) $display("FAIL round2_contaE_pulses: got %0d required %0d", conta_e, 2);
        else n_pass++;
    endtask

    task automatic test_wrong_play();
        step_t s;
        logic [19:0] e;
        int k = 0;
        add(I_JF, 5'h08);
        add(I_NONE, 5'h09);
        add(I_EQ, 5'h0A);
        add(I_NONE, 5'h07);
        add(I_JF, 5'h08);
        add(I_NONE, 5'h09);
        add(I_END, 5'h0D);
        add(I_NONE, 5'h0D, 3);
        add(I_INI, 5'h01);
        add(I_NONE, 5'h02);
        add(I_NONE, 5'h03);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL wrong_play step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_timeout();
        step_t s;
        logic [19:0] e;
        int k = 0;
        add(I_FM | I_END, 5'h06);
        add(I_NONE, 5'h07);
        add(I_NONE, 5'h07, 4000);
        add(I_TO, 5'h0E);
        add(I_NONE, 5'h0E, 2);
        add(I_INI, 5'h01);
        add(I_NONE, 5'h02);
        add(I_NONE, 5'h03);
        add(I_FM | I_END, 5'h06);
        add(I_NONE, 5'h07);
        add(I_JF | I_TO, 5'h08);
        add(I_NONE, 5'h09);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL timeout step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_win();
        step_t s;
        logic [19:0] e;
        int k = 0;
        add(I_EQ | I_END | I_FL, 5'h0C);
        add(I_NONE, 5'h0C, 5);
        add(I_INI, 5'h01);
        add(I_INI, 5'h02);
        add(I_NONE, 5'h03);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL win step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            k++;
        end
    endtask

    task automatic test_back_to_back();
        step_t s;
        logic [19:0] e;
        int k = 0;
        // iniciar held from the comparison onward: ignored in 09, restarts from 0D at once
        add(I_FM | I_END, 5'h06);
        add(I_NONE, 5'h07);
        add(I_JF, 5'h08);
        add(I_INI, 5'h09);
        add(I_INI | I_END, 5'h0D);
        add(I_INI, 5'h01);
        add(I_INI, 5'h02);
        add(I_NONE, 5'h03);
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            drive(s.in);
            exp_q.push_back(expect_vec(s.st));
            @(posedge clock); #1;
            e = exp_q.pop_front();
            n_total++;
            if (obs !== e) $display("FAIL back_to_back step %0d: got %h required %h", k, obs, e);
            else n_pass++;
            k++;
        end
    endtask

    initial begin
        test_reset();
        test_round0();
        test_round2_blank();
        test_wrong_play();
        test_timeout();
        test_win();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
